calc_sequencer: RTL and testbench

- Sequencer for the sign-magnitude calculator datapath (add/sub/mul, one-hot `sel`, 16-bit magnitude plus sign result).
- Collects operand A, operand B and the operation from board switches and a confirm button.
- Drives the datapath, waits a settle interval, then captures the result.
- Hands the captured result to the LCD writer over a req/ack handshake and reports status for board LEDs.

---
 rtl/calc_sequencer.sv | 170 +++++++++++++++++
 tb/tb_calc_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: collects operands and op from switches, drives the
// sign-magnitude datapath, captures its result and hands it to the LCD.
module calc_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LCD_TIMEOUT   = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw_val,
  input  logic        sw_sinal,
  input  logic [2:0]  op_sel,
  input  logic        btn_ok,
  input  logic        btn_clr,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic        sinal_a,
  output logic        sinal_b,
  output logic [2:0]  sel,
  input  logic [15:0] saida,
  input  logic        sinal_saida,
  output logic [15:0] res,
  output logic        sinal_res,
  output logic        lcd_req,
  input  logic        lcd_ack,
  output logic [2:0]  estado,
  output logic        err
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    DISPLAY = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [3:0]  SET_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(LCD_TIMEOUT - 1);

  state_t      state, state_n;
  logic        ok_s1, ok_s2, ok_d, ok_pulse;
  logic        clr_s1, clr_s2;
  logic [2:0]  op_q, op_n;
  logic [7:0]  a_n, b_n;
  logic        sa_n, sb_n;
  logic [15:0] res_n;
  logic        sres_n, err_n;
  logic [3:0]  set_cnt, set_cnt_n;
  logic [15:0] tmo_cnt, tmo_cnt_n;
  logic        op_ok;

  assign ok_pulse = ok_s2 & ~ok_d;
  assign op_ok    = op_sel inside {3'b100, 3'b010, 3'b001};
  assign sel      = (state == EXEC) ? op_q : 3'b000;
  assign lcd_req  = (state == DISPLAY);
  assign estado   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD_A;
      ok_s1     <= 1'b0;
      ok_s2     <= 1'b0;
      ok_d      <= 1'b0;
      clr_s1    <= 1'b0;
      clr_s2    <= 1'b0;
      op_q      <= 3'b000;
      a         <= 8'd0;
      b         <= 8'd0;
      sinal_a   <= 1'b0;
      sinal_b   <= 1'b0;
      res       <= 16'd0;
      sinal_res <= 1'b0;
      err       <= 1'b0;
      set_cnt   <= 4'd0;
      tmo_cnt   <= 16'd0;
    end else begin
      state     <= state_n;
      ok_s1     <= btn_ok;
      ok_s2     <= ok_s1;
      ok_d      <= ok_s2;
      clr_s1    <= btn_clr;
      clr_s2    <= clr_s1;
      op_q      <= op_n;
      a         <= a_n;
      b         <= b_n;
      sinal_a   <= sa_n;
      sinal_b   <= sb_n;
      res       <= res_n;
      sinal_res <= sres_n;
      err       <= err_n;
      set_cnt   <= set_cnt_n;
      tmo_cnt   <= tmo_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    a_n       = a;
    b_n       = b;
    sa_n      = sinal_a;
    sb_n      = sinal_b;
    res_n     = res;
    sres_n    = sinal_res;
    err_n     = err;
    set_cnt_n = set_cnt;
    tmo_cnt_n = tmo_cnt;
    if (clr_s2) begin
      state_n   = LOAD_A;
      op_n      = 3'b000;
      a_n       = 8'd0;
      b_n       = 8'd0;
      sa_n      = 1'b0;
      sb_n      = 1'b0;
      res_n     = 16'd0;
      sres_n    = 1'b0;
      err_n     = 1'b0;
      set_cnt_n = 4'd0;
      tmo_cnt_n = 16'd0;
    end else begin
      unique case (state)
        LOAD_A: if (ok_pulse) begin
          a_n     = sw_val;
          sa_n    = sw_sinal;
          state_n = LOAD_B;
        end
        LOAD_B: if (ok_pulse) begin
          b_n     = sw_val;
          sb_n    = sw_sinal;
          state_n = LOAD_OP;
        end
        LOAD_OP: if (ok_pulse) begin
          if (op_ok) begin
            op_n      = op_sel;
            err_n     = 1'b0;
            set_cnt_n = 4'd0;
            state_n   = EXEC;
          end else begin
            err_n = 1'b1;
          end
        end
        EXEC: begin
          if (set_cnt == SET_LAST) begin
            // a zero magnitude is always reported as positive
            res_n     = saida;
            sres_n    = sinal_saida & (|saida);
            tmo_cnt_n = 16'd0;
            state_n   = DISPLAY;
          end else begin
            set_cnt_n = set_cnt + 4'd1;
          end
        end
        DISPLAY: begin
          if (lcd_ack) begin
            state_n = DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_n   = 1'b1;
            state_n = DONE;
          end else begin
            tmo_cnt_n = tmo_cnt + 16'd1;
          end
        end
        DONE: if (ok_pulse) state_n = LOAD_A;
        default: state_n = LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: randomized scenarios against an integer reference
// of the calculator, with a registered sign-magnitude datapath model.
module tb_calc_sequencer;

  localparam int SETTLE = 2;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw_val;
  logic        sw_sinal;
  logic [2:0]  op_sel;
  logic        btn_ok;
  logic        btn_clr;
  logic [7:0]  a, b;
  logic        sinal_a, sinal_b;
  logic [2:0]  sel;
  logic [15:0] saida;
  logic        sinal_saida;
  logic [15:0] res;
  logic        sinal_res;
  logic        lcd_req;
  logic        lcd_ack;
  logic [2:0]  estado;
  logic        err;

  int nvec = 0;
  int nerr = 0;

  calc_sequencer #(.SETTLE_CYCLES(SETTLE), .LCD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .sw_val(sw_val), .sw_sinal(sw_sinal),
    .op_sel(op_sel), .btn_ok(btn_ok), .btn_clr(btn_clr),
    .a(a), .b(b), .sinal_a(sinal_a), .sinal_b(sinal_b), .sel(sel),
    .saida(saida), .sinal_saida(sinal_saida), .res(res),
    .sinal_res(sinal_res), .lcd_req(lcd_req), .lcd_ack(lcd_ack),
    .estado(estado), .err(err)
  );

  always #5 clk = ~clk;

  // naive datapath: one cycle latency, equal magnitudes take B's sign
  function automatic logic [16:0] dp_f(
    input logic [7:0] x, input logic sx,
    input logic [7:0] y, input logic sy, input logic [2:0] s);
    logic sy2;
    sy2 = sy ^ (s == 3'b010);
    if (s == 3'b001) return {sx ^ sy, 16'(x) * 16'(y)};
    if (s == 3'b100 || s == 3'b010) begin
      if (sx == sy2) return {sx, 16'(x) + 16'(y)};
      if (x > y) return {sx, 16'(x) - 16'(y)};
      return {sy2, 16'(y) - 16'(x)};
    end
    return {1'b1, 16'hDEAD};
  endfunction

  always @(posedge clk)
    {sinal_saida, saida} <= dp_f(a, sinal_a, b, sinal_b, sel);

  function automatic int ref_calc(
    input logic [7:0] x, input logic sx,
    input logic [7:0] y, input logic sy, input logic [2:0] op);
    int va, vb;
    va = sx ? -int'(x) : int'(x);
    vb = sy ? -int'(y) : int'(y);
    case (op)
      3'b100:  return va + vb;
      3'b010:  return va - vb;
      default: return va * vb;
    endcase
  endfunction

  task automatic confirm(input logic [7:0] v, input logic s,
                         input logic [2:0] op);
    @(negedge clk);
    sw_val = v; sw_sinal = s; op_sel = op; btn_ok = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_ok = 1'b0;
  endtask

  task automatic settle_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_run(input logic [7:0] xa, input logic xsa,
                        input logic [7:0] xb, input logic xsb,
                        input logic [2:0] xop, input int ack_dly);
    int r, n, k, exp_k;
    logic [15:0] em;
    logic es, e_err;
    r  = ref_calc(xa, xsa, xb, xsb, xop);
    em = 16'(r < 0 ? -r : r);
    es = (r < 0);
    confirm(xa, xsa, 3'b000);
    nvec++;
    if (estado !== 3'd1 || a !== xa || sinal_a !== xsa) begin
      nerr++;
      $display("FAIL load_a: estado=%0d a=%0d sa=%0b want 1 %0d %0b",
               estado, a, sinal_a, xa, xsa);
    end
    settle_idle();
    confirm(xb, xsb, 3'b000);
    nvec++;
    if (estado !== 3'd2 || b !== xb || sinal_b !== xsb) begin
      nerr++;
      $display("FAIL load_b: estado=%0d b=%0d sb=%0b want 2 %0d %0b",
               estado, b, sinal_b, xb, xsb);
    end
    settle_idle();
    confirm(8'd0, 1'b0, xop);
    n = 0;
    while (estado === 3'd3 && n < 20) begin
      nvec++;
      if (sel !== xop) begin
        nerr++;
        $display("FAIL exec_sel: sel=%b want %b", sel, xop);
      end
      n++;
      @(negedge clk);
    end
    nvec++;
    if (n != SETTLE) begin
      nerr++;
      $display("FAIL exec_len: %0d cycles want %0d", n, SETTLE);
    end
    nvec++;
    if (estado !== 3'd4 || lcd_req !== 1'b1 || sel !== 3'b000) begin
      nerr++;
      $display("FAIL disp_entry: estado=%0d req=%0b sel=%b want 4 1 000",
               estado, lcd_req, sel);
    end
    nvec++;
    if (res !== em || sinal_res !== es) begin
      nerr++;
      $display("FAIL result: res=%0d s=%0b want %0d %0b",
               res, sinal_res, em, es);
    end
    k = 0;
    while (estado === 3'd4 && k < 200) begin
      if (k == ack_dly) lcd_ack = 1'b1;
      @(negedge clk);
      lcd_ack = 1'b0;
      k++;
    end
    exp_k = (ack_dly < TMO) ? ack_dly + 1 : TMO;
    e_err = (ack_dly >= TMO);
    nvec++;
    if (k != exp_k) begin
      nerr++;
      $display("FAIL disp_len: %0d cycles want %0d", k, exp_k);
    end
    nvec++;
    if (estado !== 3'd5 || lcd_req !== 1'b0 || err !== e_err) begin
      nerr++;
      $display("FAIL done: estado=%0d req=%0b err=%0b want 5 0 %0b",
               estado, lcd_req, err, e_err);
    end
    settle_idle();
    confirm(8'd0, 1'b0, 3'b000);
    nvec++;
    if (estado !== 3'd0 || res !== em || a !== xa) begin
      nerr++;
      $display("FAIL done_exit: estado=%0d res=%0d a=%0d want 0 %0d %0d",
               estado, res, a, em, xa);
    end
    settle_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    nvec++;
    if (estado !== 3'd0 || a !== 8'd0 || b !== 8'd0 || sel !== 3'b000 ||
        res !== 16'd0 || sinal_res !== 1'b0 || lcd_req !== 1'b0 ||
        err !== 1'b0 || sinal_a !== 1'b0 || sinal_b !== 1'b0) begin
      nerr++;
      $display("FAIL reset: estado=%0d a=%0d b=%0d sel=%b res=%0d req=%0b err=%0b",
               estado, a, b, sel, res, lcd_req, err);
    end
    rst_n = 1'b1;
    settle_idle();
  endtask

  task automatic test_add();
    do_run(8'd25, 1'b0, 8'd10, 1'b1, 3'b100, 2);
  endtask

  task automatic test_neg_zero();
    do_run(8'd5, 1'b0, 8'd5, 1'b1, 3'b100, 0);
  endtask

  task automatic test_mul();
    do_run(8'd255, 1'b1, 8'd255, 1'b0, 3'b001, 3);
  endtask

  task automatic test_handshake();
    do_run(8'd40, 1'b1, 8'd7, 1'b1, 3'b010, 7);
  endtask

  task automatic test_timeout();
    do_run(8'd3, 1'b0, 8'd9, 1'b0, 3'b010, 1000);
  endtask

  task automatic test_invalid_op_clear();
    int g;
    confirm(8'd12, 1'b1, 3'b000);
    settle_idle();
    confirm(8'd4, 1'b0, 3'b000);
    settle_idle();
    confirm(8'd0, 1'b0, 3'b110);
    nvec++;
    if (estado !== 3'd2 || err !== 1'b1) begin
      nerr++;
      $display("FAIL bad_op: estado=%0d err=%0b want 2 1", estado, err);
    end
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_clr = 1'b0;
    nvec++;
    if (estado !== 3'd0 || err !== 1'b0 || a !== 8'd0) begin
      nerr++;
      $display("FAIL clr_loadop: estado=%0d err=%0b a=%0d want 0 0 0",
               estado, err, a);
    end
    settle_idle();
    confirm(8'd100, 1'b0, 3'b000);
    settle_idle();
    confirm(8'd3, 1'b0, 3'b000);
    settle_idle();
    confirm(8'd0, 1'b0, 3'b001);
    g = 0;
    while (estado !== 3'd4 && g < 20) begin
      @(negedge clk);
      g++;
    end
    btn_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if (estado !== 3'd4 || lcd_req !== 1'b1 || res !== 16'd300) begin
      nerr++;
      $display("FAIL clr_presync: estado=%0d req=%0b res=%0d want 4 1 300",
               estado, lcd_req, res);
    end
    @(posedge clk);
    @(negedge clk);
    btn_clr = 1'b0;
    nvec++;
    if (estado !== 3'd0 || lcd_req !== 1'b0 || res !== 16'd0 ||
        err !== 1'b0 || a !== 8'd0) begin
      nerr++;
      $display("FAIL clr_display: estado=%0d req=%0b res=%0d err=%0b a=%0d",
               estado, lcd_req, res, err, a);
    end
    settle_idle();
  endtask

  task automatic test_random();
    logic [2:0] ops [3];
    ops[0] = 3'b100; ops[1] = 3'b010; ops[2] = 3'b001;
    for (int i = 0; i < 8; i++) begin
      do_run(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
             ops[$urandom_range(0, 2)], int'($urandom_range(0, 10)));
    end
  endtask

  initial begin
    rst_n = 1'b0; sw_val = 8'd0; sw_sinal = 1'b0; op_sel = 3'b000;
    btn_ok = 1'b0; btn_clr = 1'b0; lcd_ack = 1'b0;
    test_reset();
    test_add();
    test_neg_zero();
    test_mul();
    test_handshake();
    test_timeout();
    test_invalid_op_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
